// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns low in turn, debounces the rows
// and reports one hex code per physical key press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 6000,
  parameter int DEBOUNCE_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       new_key
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CYCLES) ?
                        SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t          state;
  logic [3:0]      sync_q;
  logic [3:0]      row_s;
  logic [CW-1:0]   cnt;
  logic [1:0]      col_idx;
  logic [3:0]      cap_pat;
  logic [1:0]      cap_row;

  logic [3:0]      low;
  logic            one_low;
  logic [1:0]      low_idx;
  logic            row_bit;
  logic [1:0]      col_nxt;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r,
                                          input logic [1:0] c);
    key_code = 4'h0;
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      4'hF: key_code = 4'hD;
      default: key_code = 4'h0;
    endcase
  endfunction

  // Rows are active-low; a single low bit means one unambiguous key.
  always_comb begin
    low     = ~row_s;
    one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    low_idx = 2'd0;
    case (low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
    row_bit = row_s[cap_row];
    col_nxt = col_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 4'b1111;
      row_s     <= 4'b1111;
      state     <= SCAN;
      cnt       <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      cap_pat   <= 4'b1111;
      cap_row   <= 2'd0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      new_key   <= 1'b0;
    end else begin
      sync_q  <= row;
      row_s   <= sync_q;
      new_key <= 1'b0;
      unique case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (one_low) begin
              cap_pat <= row_s;
              cap_row <= low_idx;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_nxt;
              col     <= col_drive(col_nxt);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (row_s != cap_pat) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            key       <= key_code(cap_row, col_idx);
            key_valid <= 1'b1;
            new_key   <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (row_bit) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (!row_bit) begin
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            key_valid <= 1'b0;
            cnt       <= '0;
            col_idx   <= col_nxt;
            col       <= col_drive(col_nxt);
            state     <= SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model of the keypad,
// randomized presses and a scoreboard of expected key codes.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DB  = 8;
  localparam int LAT = 2 + 4 * SD + DB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        new_key;

  logic [15:0] pressed = '0;
  logic        prev_kv = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  typedef struct {
    logic [3:0] code;
    int         t;
  } exp_t;
  exp_t sb[$];

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key(key),
    .key_valid(key_valid),
    .new_key(new_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A row reads low when any closed switch on it meets a driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] colexp(input int c);
    logic [3:0] v;
    v = 4'b1111;
    v[c] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && new_key === 1'b1) begin
      check("new_key_expected", sb.size() > 0, 1);
      check("new_key_not_while_valid", prev_kv, 0);
      check("new_key_valid", key_valid, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("new_key_code", key, e.code);
        check("press_latency_ok", (cyc - e.t) <= LAT, 1);
      end
    end
    prev_kv = key_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_release(input int c, input logic [3:0] code);
    int n;
    n = 0;
    while (key_valid === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("release_done", key_valid, 0);
    check("key_retained", key, code);
    check("scan_resumes", col, colexp((c + 1) % 4));
  endtask

  task automatic press(input int r, input int c,
                       input bit bounce, input bit rel_bounce);
    int idx;
    idx = r * 4 + c;
    if (bounce) begin
      repeat ($urandom_range(2, 4)) begin
        pressed[idx] = 1'b1;
        wait_cycles(3);
        pressed[idx] = 1'b0;
        wait_cycles(3);
      end
    end
    pressed[idx] = 1'b1;
    sb.push_back('{kmap[idx], cyc});
    wait_cycles(40);
    check("held_valid", key_valid, 1);
    check("held_key", key, kmap[idx]);
    check("col_frozen", col, colexp(c));
    if (rel_bounce) begin
      pressed[idx] = 1'b0;
      wait_cycles($urandom_range(1, 5));
      pressed[idx] = 1'b1;
      wait_cycles(20);
      check("rel_bounce_valid", key_valid, 1);
      check("rel_bounce_key", key, kmap[idx]);
    end
    pressed[idx] = 1'b0;
    wait_release(c, kmap[idx]);
  endtask

  initial begin
    wait_cycles(2);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_key_valid", key_valid, 0);
    check("rst_new_key", new_key, 0);
    reset = 1'b1;

    for (int k = 0; k < 20; k++) begin
      check("idle_col", col, colexp((k / SD) % 4));
      @(negedge clk);
    end
    check("idle_key", key, 4'h0);
    check("idle_key_valid", key_valid, 0);

    press(1, 2, 1'b0, 1'b0);
    press(0, 0, 1'b1, 1'b0);
    press(3, 2, 1'b0, 1'b1);

    pressed[3]  = 1'b1;
    pressed[11] = 1'b1;
    wait_cycles(40);
    check("ambig_no_valid", key_valid, 0);
    check("ambig_key_kept", key, 4'hF);
    pressed[3]  = 1'b0;
    pressed[11] = 1'b0;
    wait_cycles(10);

    pressed[15] = 1'b1;
    sb.push_back('{4'hD, cyc});
    wait_cycles(40);
    pressed[3] = 1'b1;
    wait_cycles(20);
    check("second_key_ignored", key, 4'hD);
    check("second_key_valid", key_valid, 1);
    pressed[3] = 1'b0;
    wait_cycles(5);
    pressed[15] = 1'b0;
    wait_release(3, 4'hD);

    for (int i = 0; i < 12; i++) begin
      wait_cycles($urandom_range(0, 10));
      press($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    pressed[5] = 1'b1;
    sb.push_back('{4'h5, cyc});
    wait_cycles(40);
    check("pre_reset_valid", key_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_col", col, 4'b1110);
    check("async_rst_key", key, 4'h0);
    check("async_rst_key_valid", key_valid, 0);
    check("async_rst_new_key", new_key, 0);
    pressed[5] = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    check("restart_col", col, 4'b1110);
    wait_cycles(SD + 1);
    check("restart_advance", col, 4'b1101);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
